branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer plus saturating-counter direction predictor for the 5-stage RV32I pipeline.
- Looked up combinationally in IF with the current PC.
- Trained from EX when a branch or jump resolves.
- Replaces static predict-not-taken with optional gshare indexing, so correctly predicted taken control flow no longer forces an IF/ID flush.

Parameters:
ENTRIES, 64, number of BTB entries; power of 2, minimum 4
TAG_BITS, 8, PC tag bits stored per entry
CTR_BITS, 2, direction counter width; minimum 1
USE_GSHARE, 0, 1 = index is PC index XOR GHR; 0 = PC index only
GHR_BITS, 6, global history length; must be <= log2(ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_pc  in  32  IF-stage PC
pred_hit  out  1  valid entry whose tag matches fetch_pc
pred_taken  out  1  predict redirect
pred_target  out  32  predicted next PC
pred_ghr  out  GHR_BITS  GHR snapshot; pipelined alongside the instruction
upd_valid  in  1  EX resolved a branch/jump this cycle
upd_pc  in  32  PC of the resolved instruction
upd_ghr  in  GHR_BITS  pred_ghr that travelled with the instruction
upd_is_jump  in  1  JAL/JALR (unconditional)
upd_taken  in  1  actual outcome (br_en, or 1 for jumps)
upd_target  in  32  actual target ({alu_out[31:1],0} for JALR)
upd_mispredict  in  1  EX detected direction or target mispredict
mispredict_count  out  32  wrapping count of upd_valid && upd_mispredict

Behaviour:
- IDX = log2(ENTRIES).
- Index calculation:
  - idx = pc[IDX+1:2].
  - If USE_GSHARE = 1, the low GHR_BITS bits of idx are XORed with the GHR.
  - Lookup uses the live GHR; update uses upd_ghr.
- Tag = pc[IDX+TAG_BITS+1:IDX+2].
- Entry contents: valid, tag, target[31:0], ctr[CTR_BITS-1:0], is_jump.
- Lookup is purely combinational from stored state:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (is_jump || ctr[MSB]).
  - pred_target = entry target when pred_taken, else fetch_pc + 4.
- Update occurs on the rising edge when upd_valid = 1:
  - Hit, taken: ctr saturating increment (max 2^CTR_BITS-1); target <= upd_target; is_jump <= upd_is_jump.
  - Hit, not taken: ctr saturating decrement (min 0).
  - Miss, taken: allocate (overwrite) the entry; valid <= 1, tag, target, is_jump, ctr <= 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- GHR update, conditional branches only (upd_valid && !upd_is_jump):
  - upd_mispredict = 1: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This repairs speculative history.
  - Otherwise: ghr <= {ghr[GHR_BITS-2:0], upd_taken}.
  - Jumps do not touch the GHR.
  - The GHR is updated only at resolution, never speculatively in IF.
- Simultaneous lookup and update of the same entry: lookup returns the pre-update value. There is no bypass; the new value is visible the next cycle.
- mispredict_count increments by 1 per cycle with upd_valid && upd_mispredict, wrapping 0xFFFFFFFF -> 0.
- Reset (synchronous, rst = 1 at a clock edge):
  - All valid bits cleared.
  - All ctr set to 2^(CTR_BITS-1)-1 (weakly not taken).
  - GHR cleared to 0; mispredict_count cleared to 0.
  - Target and tag arrays need not be reset.
  - After reset: pred_hit = 0, pred_taken = 0, pred_target = fetch_pc + 4, pred_ghr = 0.
- Reset asserted while upd_valid = 1: reset wins; that update is discarded.
- Stalls: the block has no enable. The pipeline must present each resolved instruction on upd_valid for exactly one cycle, i.e. gate upd_valid with EX/MEM enable.
- USE_GSHARE = 0: pred_ghr is still driven and the GHR still maintained; it is simply not used for indexing.

Test Plan:
All scenarios use ENTRIES = 16, CTR_BITS = 2, USE_GSHARE = 0 unless stated.
1. Reset, then fetch_pc = 0x60 -> pred_hit = 0, pred_taken = 0, pred_target = 0x64, pred_ghr = 0.
2. Update pc = 0x60, taken, target = 0x20, branch; then fetch_pc = 0x60 -> pred_hit = 1, pred_taken = 1 (ctr = 2), pred_target = 0x20. Two not-taken updates -> ctr = 0, pred_taken = 0, pred_target = 0x64.
3. Saturation: 5 taken updates of the same branch -> ctr stays 3. A single not-taken update -> ctr = 2, still predicts taken.
4. Alias: train pc = 0x60, then taken update pc = 0x460 (same index, different tag) -> fetch 0x60 misses; fetch 0x460 hits with the new target. Same-cycle update and lookup on 0x460 returns old data that cycle, new data the next.
5. JAL at 0x100, target 0x200 -> pred_taken = 1 regardless of ctr; GHR unchanged. With USE_GSHARE = 1, GHR_BITS = 4: branches taken, taken, not-taken -> GHR = 4'b0110; then a mispredict with upd_ghr = 0, upd_taken = 1 -> GHR = 4'b0001.
6. Three mispredict updates -> mispredict_count = 3. Force the count to 0xFFFFFFFF via the bench, apply one more mispredict -> 0. rst mid-stream -> count = 0 and all lookups miss.

Source files
------------

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and EX-side training bus between the pipeline and the
// branch target buffer / direction predictor.
interface branch_predictor_btb_if #(
    parameter int GHR_BITS = 6
);
    logic [31:0]         fetch_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                upd_is_jump;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                upd_mispredict;
    logic [31:0]         mispredict_count;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_ghr, upd_is_jump, upd_taken,
               upd_target, upd_mispredict,
        input  pred_hit, pred_taken, pred_target, pred_ghr, mispredict_count
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_ghr, upd_is_jump, upd_taken,
               upd_target, upd_mispredict,
        output pred_hit, pred_taken, pred_target, pred_ghr, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters and optional gshare
// indexing; combinational lookup in IF, training from EX at resolution.
module branch_predictor_btb #(
    parameter int ENTRIES    = 64,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int USE_GSHARE = 0,
    parameter int GHR_BITS   = 6
) (
    input logic                  clk,
    input logic                  rst,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [ENTRIES-1:0]  valid;
    logic [ENTRIES-1:0]  jmp_mem;
    logic [TAG_BITS-1:0] tag_mem [ENTRIES];
    logic [31:0]         tgt_mem [ENTRIES];
    logic [CTR_BITS-1:0] ctr_mem [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         miss_cnt;

    function automatic logic [IDX-1:0] index_of(input logic [31:0] pc,
                                                 input logic [GHR_BITS-1:0] hist);
        logic [IDX-1:0] h;
        h = '0;
        if (USE_GSHARE != 0) h[GHR_BITS-1:0] = hist;
        return pc[IDX+1:2] ^ h;
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [31:0] pc);
        return pc[IDX+TAG_BITS+1:IDX+2];
    endfunction

    logic [IDX-1:0] lk_idx, up_idx;
    logic           lk_hit, up_hit, lk_taken;

    // Lookup indexes with live history; training uses the snapshot that
    // travelled with the instruction so it lands on the entry that predicted it.
    always_comb begin
        lk_idx   = index_of(bus.fetch_pc, ghr);
        lk_hit   = valid[lk_idx] && (tag_mem[lk_idx] == tag_of(bus.fetch_pc));
        lk_taken = lk_hit && (jmp_mem[lk_idx] || ctr_mem[lk_idx][CTR_BITS-1]);
        up_idx   = index_of(bus.upd_pc, bus.upd_ghr);
        up_hit   = valid[up_idx] && (tag_mem[up_idx] == tag_of(bus.upd_pc));
    end

    assign bus.pred_hit         = lk_hit;
    assign bus.pred_taken       = lk_taken;
    assign bus.pred_target      = lk_taken ? tgt_mem[lk_idx] : bus.fetch_pc + 32'd4;
    assign bus.pred_ghr         = ghr;
    assign bus.mispredict_count = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            ghr      <= '0;
            miss_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_WNT;
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    if (ctr_mem[up_idx] != CTR_MAX) ctr_mem[up_idx] <= ctr_mem[up_idx] + CTR_ONE;
                    tgt_mem[up_idx] <= bus.upd_target;
                    jmp_mem[up_idx] <= bus.upd_is_jump;
                end else if (ctr_mem[up_idx] != '0) begin
                    ctr_mem[up_idx] <= ctr_mem[up_idx] - CTR_ONE;
                end
            end else if (bus.upd_taken) begin
                valid[up_idx]   <= 1'b1;
                tag_mem[up_idx] <= tag_of(bus.upd_pc);
                tgt_mem[up_idx] <= bus.upd_target;
                jmp_mem[up_idx] <= bus.upd_is_jump;
                ctr_mem[up_idx] <= CTR_WT;
            end
            // A mispredict rebuilds history from the instruction's own snapshot.
            if (!bus.upd_is_jump) begin
                if (bus.upd_mispredict) ghr <= {bus.upd_ghr[GHR_BITS-2:0], bus.upd_taken};
                else                    ghr <= {ghr[GHR_BITS-2:0], bus.upd_taken};
            end
            if (bus.upd_mispredict) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.fetch_pc[31:IDX+TAG_BITS+2], bus.fetch_pc[1:0],
                           bus.upd_pc[31:IDX+TAG_BITS+2], bus.upd_pc[1:0],
                           bus.upd_ghr[GHR_BITS-1]};
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: expected lookups are queued when fetch_pc is driven and
// compared once the combinational prediction has settled.
module tb_branch_predictor_btb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_btb_if #(.GHR_BITS(4)) bus ();
    branch_predictor_btb_if #(.GHR_BITS(4)) gbus ();

    branch_predictor_btb #(.ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .USE_GSHARE(0), .GHR_BITS(4))
        dut (.clk(clk), .rst(rst), .bus(bus));
    branch_predictor_btb #(.ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .USE_GSHARE(1), .GHR_BITS(4))
        dut_g (.clk(clk), .rst(rst), .bus(gbus));

    typedef struct {
        string       tag;
        bit          g;
        bit          hit;
        bit          taken;
        logic [31:0] target;
        logic [3:0]  ghr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  exp_ghr = '0;
    logic [31:0] exp_cnt = '0;
    logic [3:0]  ghr_before;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.g) begin
                check({e.tag, ".hit"},    32'(gbus.pred_hit),    32'(e.hit));
                check({e.tag, ".taken"},  32'(gbus.pred_taken),  32'(e.taken));
                check({e.tag, ".target"}, gbus.pred_target,      e.target);
                check({e.tag, ".ghr"},    32'(gbus.pred_ghr),    32'(e.ghr));
            end else begin
                check({e.tag, ".hit"},    32'(bus.pred_hit),     32'(e.hit));
                check({e.tag, ".taken"},  32'(bus.pred_taken),   32'(e.taken));
                check({e.tag, ".target"}, bus.pred_target,       e.target);
                check({e.tag, ".ghr"},    32'(bus.pred_ghr),     32'(e.ghr));
            end
        end
    endtask

    task automatic look(input bit g, input logic [31:0] pc, input bit hit, input bit taken,
                        input logic [31:0] tgt, input logic [3:0] ghr, input string tag);
        exp_t e;
        if (g) gbus.fetch_pc = pc;
        else   bus.fetch_pc  = pc;
        e.tag = tag; e.g = g; e.hit = hit; e.taken = taken; e.target = tgt; e.ghr = ghr;
        sb.push_back(e);
        #1;
        drain();
    endtask

    // Drives one update on the main predictor and advances the reference history/count.
    task automatic set_upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                           input bit jmp, input bit mis, input logic [3:0] ughr);
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = taken; bus.upd_target = tgt;
        bus.upd_is_jump = jmp; bus.upd_mispredict = mis; bus.upd_ghr = ughr;
        if (!jmp) exp_ghr = mis ? {ughr[2:0], taken} : {exp_ghr[2:0], taken};
        if (mis) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                       input bit jmp, input bit mis, input logic [3:0] ughr);
        @(negedge clk);
        set_upd(pc, taken, tgt, jmp, mis, ughr);
        @(negedge clk);
        bus.upd_valid = 1'b0;
    endtask

    task automatic gupd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                        input bit mis, input logic [3:0] ughr);
        @(negedge clk);
        gbus.upd_valid = 1'b1; gbus.upd_pc = pc; gbus.upd_taken = taken; gbus.upd_target = tgt;
        gbus.upd_is_jump = 1'b0; gbus.upd_mispredict = mis; gbus.upd_ghr = ughr;
        @(negedge clk);
        gbus.upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.fetch_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_ghr = '0;
        bus.upd_is_jump = 0; bus.upd_taken = 0; bus.upd_target = '0; bus.upd_mispredict = 0;
        gbus.fetch_pc = '0; gbus.upd_valid = 0; gbus.upd_pc = '0; gbus.upd_ghr = '0;
        gbus.upd_is_jump = 0; gbus.upd_taken = 0; gbus.upd_target = '0; gbus.upd_mispredict = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        look(0, 32'h60, 0, 0, 32'h64, 4'h0, "rst_look");
        check("rst_cnt", bus.mispredict_count, 32'h0);

        // Allocate weakly taken, then train down
        upd(32'h60, 1, 32'h20, 0, 0, 4'h0);
        look(0, 32'h60, 1, 1, 32'h20, exp_ghr, "alloc");
        upd(32'h60, 0, 32'h0, 0, 0, 4'h0);
        look(0, 32'h60, 1, 0, 32'h64, exp_ghr, "nt1");
        upd(32'h60, 0, 32'h0, 0, 0, 4'h0);
        look(0, 32'h60, 1, 0, 32'h64, exp_ghr, "nt2");

        // Saturation: 0 -> 3 after five taken; two not-taken reach 1
        for (int i = 0; i < 5; i++) upd(32'h60, 1, 32'h20, 0, 0, 4'h0);
        look(0, 32'h60, 1, 1, 32'h20, exp_ghr, "sat");
        upd(32'h60, 0, 32'h0, 0, 0, 4'h0);
        look(0, 32'h60, 1, 1, 32'h20, exp_ghr, "sat_nt1");
        upd(32'h60, 0, 32'h0, 0, 0, 4'h0);
        look(0, 32'h60, 1, 0, 32'h64, exp_ghr, "sat_nt2");

        // Alias overwrite, then same-cycle update/lookup
        upd(32'h460, 1, 32'h300, 0, 0, 4'h0);
        look(0, 32'h60, 0, 0, 32'h64, exp_ghr, "alias_old");
        look(0, 32'h460, 1, 1, 32'h300, exp_ghr, "alias_new");
        @(negedge clk);
        ghr_before = exp_ghr;
        set_upd(32'h460, 1, 32'h340, 0, 0, 4'h0);
        look(0, 32'h460, 1, 1, 32'h300, ghr_before, "same_cycle");
        @(negedge clk);
        bus.upd_valid = 1'b0;
        look(0, 32'h460, 1, 1, 32'h340, exp_ghr, "next_cycle");

        // Jump predicts taken regardless of counter; history untouched
        upd(32'h100, 1, 32'h200, 1, 0, 4'h0);
        look(0, 32'h100, 1, 1, 32'h200, exp_ghr, "jal");
        upd(32'h100, 0, 32'h0, 1, 0, 4'h0);
        upd(32'h100, 0, 32'h0, 1, 0, 4'h0);
        look(0, 32'h100, 1, 1, 32'h200, exp_ghr, "jal_ctr0");

        // Gshare history and indexing
        gupd(32'h60, 1, 32'h20, 0, 4'h0);
        gupd(32'h60, 1, 32'h20, 0, 4'h0);
        gupd(32'h60, 0, 32'h0, 0, 4'h0);
        check("g_ghr_tnt", 32'(gbus.pred_ghr), 32'h6);
        gupd(32'h60, 1, 32'h20, 1, 4'h0);
        check("g_ghr_repair", 32'(gbus.pred_ghr), 32'h1);
        gupd(32'h80, 1, 32'h500, 0, 4'h3);
        look(1, 32'h80, 1, 1, 32'h500, 4'h3, "g_hit");
        gupd(32'h1000, 0, 32'h0, 0, 4'h0);
        look(1, 32'h80, 0, 0, 32'h84, 4'h6, "g_miss");

        // Mispredict counter and wrap
        for (int i = 0; i < 3; i++) upd(32'h2000, 0, 32'h0, 0, 1, 4'h0);
        check("cnt3", bus.mispredict_count, exp_cnt);
        check("cnt3_abs", bus.mispredict_count, 32'd3);
        @(negedge clk);
        force dut.miss_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        check("cnt_forced", bus.mispredict_count, exp_cnt);
        upd(32'h2000, 0, 32'h0, 0, 1, 4'h0);
        check("cnt_wrap", bus.mispredict_count, 32'h0);

        // Reset wins over a concurrent update
        @(negedge clk);
        set_upd(32'h2000, 1, 32'h900, 0, 1, 4'h5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.upd_valid = 1'b0;
        exp_cnt = '0;
        exp_ghr = '0;
        check("rst2_cnt", bus.mispredict_count, exp_cnt);
        look(0, 32'h60, 0, 0, 32'h64, exp_ghr, "rst2_60");
        look(0, 32'h460, 0, 0, 32'h464, exp_ghr, "rst2_460");
        look(0, 32'h100, 0, 0, 32'h104, exp_ghr, "rst2_100");
        look(0, 32'h2000, 0, 0, 32'h2004, exp_ghr, "rst2_2000");
        look(1, 32'h80, 0, 0, 32'h84, 4'h0, "rst2_g80");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
